cnn_layer_sequencer: RTL
========================

# cnn_layer_sequencer

Parametrised layer sequencer for the CNN core, generalising the fixed conv/pool/FC controller to NUM_LAYERS engines. It drives one-cycle start pulses to each enabled layer in index order, waits on per-layer done, and enforces a per-layer watchdog timeout. It also supports abort, per-layer bypass and a continuous (free-running) mode, and latches the final result. It sits between the core's top-level enable/result interface and the layer engines' start/done handshakes.

## Interface
- NUM_LAYERS, 3: number of sequenced layers (≥1); layer 0 runs first.
- TIMEOUT_W, 16: width of watchdog limit/timer.
- RESULT_W, 32: width of result_in/value.
- CNT_W, 32: width of cycle_count.
- Derived: LIDX_W = max(1, clog2(NUM_LAYERS)).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  run request; start on rising edge; level keeps continuous mode looping.
- continuous  in  1  1: restart automatically after DONE while enable high.
- abort  in  1  return to IDLE immediately.
- bypass_mask  in  NUM_LAYERS  bit i=1 skips layer i; sampled at start.
- timeout_limit  in  TIMEOUT_W  max WAIT cycles per layer; 0 disables; sampled at start.
- layer_done  in  NUM_LAYERS  per-layer completion pulse/level.
- result_in  in  RESULT_W  last layer's output, valid when its done is high.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse.
- busy  out  1  high in any state but IDLE/ERROR.
- done  out  1  one-cycle completion pulse.
- value  out  RESULT_W  result captured at completion.
- error  out  1  sticky timeout flag.
- err_layer  out  LIDX_W  layer that timed out.
- cur_layer  out  LIDX_W  layer currently active.
- cycle_count  out  CNT_W  cycles of last/current run, saturating.

## Operation
- All outputs registered. Reset (rst=0 at clock edge): state IDLE; layer_start, busy, done, error, err_layer, cur_layer, value, cycle_count all 0; enable history cleared to 0.
- States: IDLE, START, WAIT, DONE, ERROR.
- IDLE: on enable rising edge (enable=1, previous sample 0) latch bypass_mask/timeout_limit, clear error and cycle_count. If every layer is bypassed, go to DONE with value <= result_in. Otherwise set cur_layer to the lowest unbypassed index and go to START.
- START: layer_start[cur_layer]=1 for exactly this cycle; timer cleared. Go to WAIT. layer_done is ignored in START.
- WAIT: sample layer_done[cur_layer]. If high, move to the next unbypassed index above cur_layer and go to START. If no such index exists, capture value <= result_in and go to DONE. Otherwise, when timeout_limit≠0 and timer==timeout_limit-1, go to ERROR with error=1 and err_layer=cur_layer. The timer increments each WAIT cycle. done bits of non-current layers are ignored.
- DONE: done=1 for this cycle only. If continuous=1 and enable=1, relatch config and go to START of the first unbypassed layer (no IDLE cycle). Otherwise go to IDLE; a new run then needs a fresh enable rising edge.
- ERROR: error stays 1 and no layer_start is issued. Leave to IDLE when enable=0. error clears only on the next accepted start or reset.
- abort=1 in START/WAIT/DONE: next state IDLE. Abort beats layer_done, timeout and the DONE pulse in the same cycle; no layer_start or done follows. value is unchanged. abort in IDLE/ERROR has no effect.
- cycle_count: counts every cycle in START/WAIT/DONE of the current run and saturates at all-ones. It holds its value in IDLE/ERROR.

## Timing
- Enable edge at cycle t (IDLE) → START at t+1 (layer_start high) → WAIT from t+2.
- layer_done sampled in WAIT at cycle d → next layer_start at d+1. Layer-to-layer overhead is 1 idle cycle.
- Last done at d → done and value valid at d+1.
- Minimum run for N active layers, each returning done on its first WAIT cycle: 2N+1 cycles from the enable edge to done.
- Timeout: the ERROR transition occurs on the timeout_limit-th WAIT cycle without done; error is visible the following cycle.
- Reset mid-run takes effect at the next edge. All outputs are 0 the cycle after, including any in-flight layer_start.

## Test plan
- Basic: NUM_LAYERS=3, no bypass, each layer_done 4 cycles after its start, result_in=32'hDEAD_BEEF at last done. Required: start pulses on layers 0,1,2 in order, a single done pulse, value=DEADBEEF, cycle_count=16.
- Bypass: bypass_mask=3'b010. Required: only layers 0 and 2 get layer_start. With mask 3'b111, done is asserted 1 cycle after the enable edge with no layer_start.
- Timeout: timeout_limit=5, layer 1 never signals done. Required: ERROR after 5 WAIT cycles, error=1, err_layer=1, busy=0. It recovers to IDLE after enable=0, and a new run clears error.
- Abort: assert abort in the same cycle as layer_done[0]. Required: IDLE next cycle, no layer_start[1], no done, value unchanged.
- Continuous: continuous=1, enable held high for 3 runs. Required: 3 done pulses, START directly after each DONE, and no restart after enable drops.
- Reset mid-WAIT (rst=0 for one cycle). Required: all outputs 0 the next cycle, and a held-high enable does not restart until it is deasserted and reasserted.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Sequences NUM_LAYERS engine start/done handshakes in index order, with bypass,
// per-layer watchdog, abort and free-running restart; all outputs registered.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT_W  = 16,
  parameter int RESULT_W   = 32,
  parameter int CNT_W      = 32,
  localparam int LIDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] bypass_mask,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [RESULT_W-1:0]   result_in,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  done,
  output logic [RESULT_W-1:0]   value,
  output logic                  error,
  output logic [LIDX_W-1:0]     err_layer,
  output logic [LIDX_W-1:0]     cur_layer,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERROR} state_t;

  state_t                state, state_n;
  logic                  enable_q, armed;
  logic [NUM_LAYERS-1:0] byp, byp_n;
  logic [TIMEOUT_W-1:0]  tlim, tlim_n, timer, timer_n;
  logic [LIDX_W-1:0]     cur_n, err_layer_n;
  logic [RESULT_W-1:0]   value_n;
  logic                  error_n, busy_n, done_n, launch, in_run, start_ok;
  logic [CNT_W-1:0]      cnt_n;
  logic [NUM_LAYERS-1:0] start_n;
  logic [LIDX_W:0]       first_idx, next_idx;

  // Returns {found, index} of the lowest unbypassed layer at or above lo.
  function automatic logic [LIDX_W:0] find_active(input logic [NUM_LAYERS-1:0] mask,
                                                  input int lo);
    logic [LIDX_W:0] r;
    r = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i >= lo && !mask[i]) r = {1'b1, LIDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    byp_n       = byp;
    tlim_n      = tlim;
    timer_n     = timer;
    cur_n       = cur_layer;
    err_layer_n = err_layer;
    value_n     = value;
    error_n     = error;
    launch      = 1'b0;
    in_run      = (state == START) || (state == WAIT) || (state == DONE);
    // A held-high enable after reset must drop once before it can start a run.
    start_ok    = enable && !enable_q && armed;
    first_idx   = find_active(bypass_mask, 0);
    next_idx    = find_active(byp, int'(cur_layer) + 1);

    cnt_n = cycle_count;
    if (in_run && cycle_count != '1) cnt_n = cycle_count + CNT_W'(1);

    if (abort && in_run) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_ok) launch = 1'b1;
        START: begin
          timer_n = '0;
          state_n = WAIT;
        end
        WAIT: begin
          timer_n = timer + TIMEOUT_W'(1);
          if (layer_done[cur_layer]) begin
            if (next_idx[LIDX_W]) begin
              cur_n   = next_idx[LIDX_W-1:0];
              state_n = START;
            end else begin
              value_n = result_in;
              state_n = DONE;
            end
          end else if (tlim != '0 && timer == tlim - TIMEOUT_W'(1)) begin
            error_n     = 1'b1;
            err_layer_n = cur_layer;
            state_n     = ERROR;
          end
        end
        DONE: begin
          if (continuous && enable) launch = 1'b1;
          else                      state_n = IDLE;
        end
        ERROR: if (!enable) state_n = IDLE;
        default: state_n = IDLE;
      endcase

      if (launch) begin
        byp_n   = bypass_mask;
        tlim_n  = timeout_limit;
        error_n = 1'b0;
        cnt_n   = '0;
        if (!first_idx[LIDX_W]) begin
          value_n = result_in;
          state_n = DONE;
        end else begin
          cur_n   = first_idx[LIDX_W-1:0];
          state_n = START;
        end
      end
    end

    start_n = '0;
    if (state_n == START) start_n[cur_n] = 1'b1;
    busy_n = (state_n == START) || (state_n == WAIT) || (state_n == DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      enable_q    <= 1'b0;
      armed       <= 1'b0;
      byp         <= '0;
      tlim        <= '0;
      timer       <= '0;
      layer_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      value       <= '0;
      error       <= 1'b0;
      err_layer   <= '0;
      cur_layer   <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      enable_q    <= enable;
      armed       <= armed | !enable;
      byp         <= byp_n;
      tlim        <= tlim_n;
      timer       <= timer_n;
      layer_start <= start_n;
      busy        <= busy_n;
      done        <= done_n;
      value       <= value_n;
      error       <= error_n;
      err_layer   <= err_layer_n;
      cur_layer   <= cur_n;
      cycle_count <= cnt_n;
    end
  end

endmodule
